// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply/divide engine that owns the HI/LO result
// registers.
//
// MUL is a radix-2 shift-add over WIDTH cycles. DIV is restoring division, also WIDTH
// cycles. A final FIX cycle applies sign correction, writes HI/LO and pulses done.
// A DIV/DIVU with a zero divisor skips straight to FIX, leaves HI/LO untouched and pulses
// div_zero together with done.
//
// Optional feature: define MULDIV_EARLY_OUT_EN to let MUL stop as soon as the remaining
// multiplier magnitude is zero. DIV timing does not change.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset
//   start    - launch request, sampled only while idle
//   op       - 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b     - multiplicand/dividend and multiplier/divisor
//   busy     - operation in progress
//   done     - one-cycle pulse; hi/lo valid from this cycle
//   div_zero - one-cycle pulse with done when a divide had b == 0
//   hi, lo   - MUL: product upper/lower half; DIV: remainder/quotient
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned     CntW    = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e state_q, state_d;

  logic               div_q, div_d;    // operation is a divide
  logic               neg_q, neg_d;    // negate product / quotient in FIX
  logic               rneg_q, rneg_d;  // negate remainder in FIX
  logic               zero_q, zero_d;  // divide by zero
  logic [CntW-1:0]    cnt_q, cnt_d;
  // MUL: multiplicand shifting left. DIV: divisor in the low half.
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  // MUL: multiplier shifting right. DIV: dividend bits leave at the top, quotient bits
  // enter at the bottom.
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  // MUL: product accumulator. DIV: partial remainder in bits [WIDTH:0].
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d, dz_q, dz_d;

  // Operand decode: magnitudes are taken only for signed ops.
  logic             is_signed, is_div, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign is_signed = ~op[0];
  assign is_div    = op[1];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Per-iteration datapath.
  logic [WIDTH-1:0] mplier_sh;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] rem_diff;  // MSB set means the trial subtraction went negative
  logic             mul_last;

  assign mplier_sh = mplier_q >> 1;
  assign rem_sh    = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
  assign rem_diff  = {1'b0, rem_sh} - {2'b00, mcand_q[WIDTH-1:0]};

`ifdef MULDIV_EARLY_OUT_EN
  assign mul_last = (cnt_q == CntOne) || (mplier_sh == '0);
`else
  assign mul_last = (cnt_q == CntOne);
`endif

  // Sign fix-up applied in FIX.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -mplier_q : mplier_q;
  assign rem_fix  = rneg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (is_div) begin
            state_d = (b == '0) ? StFix : StDiv;
          end else begin
`ifdef MULDIV_EARLY_OUT_EN
            state_d = (b == '0) ? StFix : StMul;
`else
            state_d = StMul;
`endif
          end
        end
      end
      StMul:   if (mul_last) state_d = StFix;
      StDiv:   if (cnt_q == CntOne) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state logic.
  always_comb begin
    div_d    = div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          div_d    = is_div;
          neg_d    = a_neg ^ b_neg;
          rneg_d   = is_div & a_neg;
          zero_d   = is_div & (b == '0);
          cnt_d    = CntLoad;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, (is_div ? b_mag : a_mag)};
          mplier_d = is_div ? a_mag : b_mag;
        end
      end
      StMul: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_sh;
        cnt_d    = cnt_q - CntOne;
      end
      StDiv: begin
        if (!rem_diff[WIDTH+1]) begin
          acc_d[WIDTH:0] = rem_diff[WIDTH:0];
          mplier_d       = {mplier_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d[WIDTH:0] = rem_sh;
          mplier_d       = {mplier_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CntOne;
      end
      StFix: begin
        done_d = 1'b1;
        dz_d   = zero_q;
        cnt_d  = '0;
        // A zero divisor leaves the previous result in place.
        if (!zero_q) begin
          if (div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  // Outputs.
  always_comb begin
    busy     = (state_q != StIdle);
    done     = done_q;
    div_zero = dz_q;
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule
